// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: write-back select encodings and widths.
package mips_pkg;

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_mux.sv
// Write-back value selector driven by the MEM/WB MemtoReg field.
module wb_mux #(
    parameter int unsigned DW = 32
) (
    input  logic [1:0]    sel,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] read_data,
    input  logic [DW-1:0] link_addr,
    output logic [DW-1:0] write_data
);
    import mips_pkg::*;

    always_comb begin
        write_data = '0;
        case (wb_sel_e'(sel))
            WB_ALU:  write_data = alu_result;
            WB_MEM:  write_data = read_data;
            WB_LINK: write_data = link_addr;
            default: write_data = '0;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// MIPS32 write-back stage and 32x32 register file with write-through bypass
// on both decode read ports and a committed-write counter.
module wb_regfile #(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               MemtoReg,
    input  logic                     RegWrite,
    input  logic [DW-1:0]            ReadData,
    input  logic [DW-1:0]            alu_result,
    input  logic [DW-1:0]            link_addr,
    input  logic [$clog2(NREG)-1:0]  WriteRegister,
    input  logic [$clog2(NREG)-1:0]  ReadRegister1,
    input  logic [$clog2(NREG)-1:0]  ReadRegister2,
    output logic [DW-1:0]            ReadData1,
    output logic [DW-1:0]            ReadData2,
    output logic [DW-1:0]            WriteData,
    output logic                     wb_valid,
    output logic [31:0]              wb_count
);
    import mips_pkg::*;

    localparam int unsigned AW = $clog2(NREG);

    // Index 0 is hardwired to zero, so the array starts at 1.
    logic [DW-1:0]    regs_q [1:NREG-1];
    logic [DW-1:0]    regs_d [1:NREG-1];
    logic [CNT_W-1:0] wb_count_q;
    logic [CNT_W-1:0] wb_count_d;

    wb_mux #(.DW(DW)) u_wb_mux (
        .sel        (MemtoReg),
        .alu_result (alu_result),
        .read_data  (ReadData),
        .link_addr  (link_addr),
        .write_data (WriteData)
    );

    assign wb_valid = RegWrite
                    && (WriteRegister != AW'(REG_ZERO))
                    && (MemtoReg != WB_RSVD);

    always_comb begin
        for (int unsigned i = 1; i < NREG; i++) begin
            regs_d[i] = (wb_valid && (WriteRegister == AW'(i))) ? WriteData : regs_q[i];
        end
        wb_count_d = wb_valid ? wb_count_q + CNT_W'(1) : wb_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wb_count_q <= wb_count_d;
        end
    end

    // Read ports: zero register first, then same-cycle bypass, then storage.
    always_comb begin
        ReadData1 = '0;
        if (ReadRegister1 != AW'(REG_ZERO)) begin
            if (wb_valid && (WriteRegister == ReadRegister1)) begin
                ReadData1 = WriteData;
            end else begin
                ReadData1 = regs_q[ReadRegister1];
            end
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (ReadRegister2 != AW'(REG_ZERO)) begin
            if (wb_valid && (WriteRegister == ReadRegister2)) begin
                ReadData2 = WriteData;
            end else begin
                ReadData2 = regs_q[ReadRegister2];
            end
        end
    end

    assign wb_count = 32'(wb_count_q);

endmodule
